// File: rtl/pkt_queue.sv
// pkt_queue: multi-packet length-framed buffer with a shared data store and a length queue
module pkt_queue #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 4,
    parameter int LEN_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         len_we,
    input  logic [LEN_W-1:0]             len_in,
    input  logic                         data_we,
    input  logic [DATA_W-1:0]            data_in,
    output logic [LEN_W-1:0]             len_out,
    input  logic                         data_rd,
    output logic [DATA_W-1:0]            data_out,
    output logic                         pkt_avail,
    output logic                         read_complete,
    output logic [$clog2(MAX_PKTS):0]    pkt_cnt,
    output logic                         q_full,
    output logic                         err_ovf,
    output logic                         err_udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int PW = MAX_PKTS > 1 ? $clog2(MAX_PKTS) : 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;
    localparam int XW = LEN_W > FW ? LEN_W : FW;

    typedef enum logic {W_IDLE, W_DATA} wstate_t;

    wstate_t           state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]     free_q, free_d;
    logic [LEN_W-1:0]  rem_q, rem_d, cur_len_q, cur_len_d, rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]     lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rc_q, rc_d, full_q, full_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  lq [MAX_PKTS];

    logic             avail, len_ok, accept, wr_en, commit, pop, pop_last;
    logic [LEN_W-1:0] head_len;

    assign avail    = cnt_q != '0;
    assign head_len = lq[lq_rp_q];
    // Space is checked against the pre-cycle free count, so a same-cycle pop never helps.
    assign len_ok   = len_in != '0 && XW'(len_in) <= XW'(free_q) && cnt_q != CW'(MAX_PKTS);
    assign accept   = state_q == W_IDLE && len_we && len_ok;
    assign wr_en    = state_q == W_DATA && data_we;
    assign commit   = wr_en && rem_q == LEN_W'(1);
    assign pop      = data_rd && avail;
    assign pop_last = pop && (rd_cnt_q + LEN_W'(1)) == head_len;

    assign len_out       = avail ? head_len : '0;
    assign data_out      = avail ? mem[rd_ptr_q] : '0;
    assign pkt_avail     = avail;
    assign read_complete = rc_q;
    assign pkt_cnt       = cnt_q;
    assign q_full        = full_q;
    assign err_ovf       = ovf_q;
    assign err_udf       = udf_q;

    // Next-state for the write FSM, pointers, counters and sticky error flags.
    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        rem_d     = rem_q;
        if (accept) begin
            state_d   = W_DATA;
            cur_len_d = len_in;
            rem_d     = len_in;
        end else if (wr_en) begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = commit ? W_IDLE : W_DATA;
        end
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_cnt_d = pop_last ? '0 : pop ? rd_cnt_q + LEN_W'(1) : rd_cnt_q;
        lq_wp_d  = !commit ? lq_wp_q : lq_wp_q == PW'(MAX_PKTS - 1) ? '0 : lq_wp_q + PW'(1);
        lq_rp_d  = !pop_last ? lq_rp_q : lq_rp_q == PW'(MAX_PKTS - 1) ? '0 : lq_rp_q + PW'(1);
        cnt_d    = cnt_q + CW'(commit) - CW'(pop_last);
        free_d   = free_q - (accept ? FW'(len_in) : '0) + FW'(pop);
        full_d   = cnt_d == CW'(MAX_PKTS) || (state_d == W_DATA && free_d == '0);
        rc_d     = pop_last;
        ovf_d    = ovf_q | (len_we && !accept) | (data_we && state_q == W_IDLE);
        udf_d    = udf_q | (data_rd && !avail);
    end

    // Control state; flush clears it synchronously with priority over all other inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= W_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            free_q    <= FW'(DEPTH);
            rem_q     <= '0;
            cur_len_q <= '0;
            rd_cnt_q  <= '0;
            lq_wp_q   <= '0;
            lq_rp_q   <= '0;
            cnt_q     <= '0;
            rc_q      <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else if (flush) begin
            state_q   <= W_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            free_q    <= FW'(DEPTH);
            rem_q     <= '0;
            cur_len_q <= '0;
            rd_cnt_q  <= '0;
            lq_wp_q   <= '0;
            lq_rp_q   <= '0;
            cnt_q     <= '0;
            rc_q      <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            free_q    <= free_d;
            rem_q     <= rem_d;
            cur_len_q <= cur_len_d;
            rd_cnt_q  <= rd_cnt_d;
            lq_wp_q   <= lq_wp_d;
            lq_rp_q   <= lq_rp_d;
            cnt_q     <= cnt_d;
            rc_q      <= rc_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Data store and length queue; contents need no reset since outputs are gated by pkt_avail.
    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_ptr_q] <= data_in;
        if (commit && !flush)
            lq[lq_wp_q] <= cur_len_q;
    end
endmodule
